game_round_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 41 ++++
 rtl/button_debounce.sv | 63 ++++++
 rtl/game_round_ctrl.sv | 134 +++++++++++++
 tb/tb_game_round_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Brief    : Shared types, constants and helpers for the binary-guessing game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SHOW   = 2'd1,
    PH_INPUT  = 2'd2,
    PH_RESULT = 2'd3
  } phase_t;

  localparam logic [7:0]        LFSR_TAPS = 8'hB8;
  localparam logic signed [7:0] SCORE_MAX = 8'sd127;
  localparam logic signed [7:0] SCORE_MIN = -8'sd128;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, feedback shifted into the LSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic signed [7:0] score_step(input logic signed [7:0] s,
                                                   input logic up);
    logic signed [8:0] sum;
    sum = up ? ({s[7], s} + 9'sd1) : ({s[7], s} - 9'sd1);
    if (sum > 9'sd127) begin
      return SCORE_MAX;
    end else if (sum < -9'sd128) begin
      return SCORE_MIN;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Brief    : Synchronises and debounces a raw button; one-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic pulse
);

  localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             pulse_q;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Only a released-to-pressed change of the accepted level produces a pulse
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_async;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/game_round_ctrl.sv
// ============================================================================
// Module   : game_round_ctrl
// Brief    : Round sequencer, LFSR target, shared timer and saturating score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SHOW_CYCLES     = 200000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000000,
  parameter int unsigned RESULT_CYCLES   = 200000000,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn_submit,
  output logic [7:0] number,
  output logic [1:0] phase,
  output logic       last_correct,
  output logic       round_done
);

  localparam logic [31:0] SHOW_LOAD    = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RESULT_LOAD  = 32'(RESULT_CYCLES - 1);

  logic submit_pulse;

  phase_t            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        target_q, target_d;
  logic signed [7:0] score_q, score_d;
  logic [7:0]        number_q, number_d;
  logic              last_correct_q, last_correct_d;
  logic              round_done_q, round_done_d;
  logic              correct;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_submit_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_async (btn_submit),
    .pulse     (submit_pulse)
  );

  always_comb begin
    state_d        = state_q;
    timer_d        = (timer_q != 32'd0) ? timer_q - 32'd1 : timer_q;
    lfsr_d         = lfsr_next(lfsr_q);
    target_d       = target_q;
    score_d        = score_q;
    last_correct_d = last_correct_q;
    round_done_d   = 1'b0;
    correct        = 1'b0;

    case (state_q)
      PH_IDLE: begin
        if (submit_pulse) begin
          target_d = lfsr_q;
          timer_d  = SHOW_LOAD;
          state_d  = PH_SHOW;
        end
      end
      PH_SHOW: begin
        if (timer_q == 32'd0) begin
          timer_d = TIMEOUT_LOAD;
          state_d = PH_INPUT;
        end
      end
      PH_INPUT: begin
        // A submit landing on the timeout cycle still counts as a guess
        if (submit_pulse || (timer_q == 32'd0)) begin
          correct        = submit_pulse && (sw == target_q);
          round_done_d   = 1'b1;
          last_correct_d = correct;
          score_d        = score_step(score_q, correct);
          timer_d        = RESULT_LOAD;
          state_d        = PH_RESULT;
        end
      end
      PH_RESULT: begin
        if (timer_q == 32'd0) begin
          target_d = lfsr_q;
          timer_d  = SHOW_LOAD;
          state_d  = PH_SHOW;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    // Display value follows the phase being entered so it lines up with phase
    case (state_d)
      PH_SHOW:  number_d = target_d;
      PH_INPUT: number_d = sw;
      default:  number_d = score_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= PH_IDLE;
      timer_q        <= 32'd0;
      lfsr_q         <= LFSR_SEED;
      target_q       <= 8'd0;
      score_q        <= 8'sd0;
      number_q       <= 8'd0;
      last_correct_q <= 1'b0;
      round_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lfsr_q         <= lfsr_d;
      target_q       <= target_d;
      score_q        <= score_d;
      number_q       <= number_d;
      last_correct_q <= last_correct_d;
      round_done_q   <= round_done_d;
    end
  end

  assign number       = number_q;
  assign phase        = state_q;
  assign last_correct = last_correct_q;
  assign round_done   = round_done_q;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// ============================================================================
// Module   : tb_game_round_ctrl
// Brief    : Scoreboard bench for game_round_ctrl with a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'd0;
  logic       btn_submit = 1'b0;
  logic [7:0] number;
  logic [1:0] phase;
  logic       last_correct;
  logic       round_done;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SHOW_CYCLES     (8),
    .TIMEOUT_CYCLES  (20),
    .RESULT_CYCLES   (6),
    .LFSR_SEED       (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_submit   (btn_submit),
    .number       (number),
    .phase        (phase),
    .last_correct (last_correct),
    .round_done   (round_done)
  );

  typedef struct {
    logic       correct;
    logic [7:0] score;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         model_score = 0;
  int         show_entries = 0;
  logic [7:0] m_lfsr_cur = 8'hA5;
  logic [7:0] m_lfsr_prev = 8'hA5;
  logic [7:0] m_target = 8'd0;
  logic [1:0] prev_phase = 2'd0;

  // Reference sequence from the polynomial x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_ref(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic corr);
    exp_t e;
    model_score = corr ? model_score + 1 : model_score - 1;
    if (model_score > 127)  model_score = 127;
    if (model_score < -128) model_score = -128;
    e.correct = corr;
    e.score   = 8'(model_score);
    sb_q.push_back(e);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget, input string name);
    int n;
    n = 0;
    while (phase !== p && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {30'd0, phase}, {30'd0, p});
  endtask

  // kind: 0 correct press, 1 wrong press, 2 timeout, 3 press landing on timeout cycle
  task automatic do_round(input int kind);
    logic [7:0] prev_sw;
    int         n;
    wait_phase(2'd2, 60, "enter_input");
    case (kind)
      0, 1: begin
        sw = (kind == 0) ? m_target : (m_target ^ 8'($urandom_range(1, 255)));
        push_exp(kind == 0);
        repeat ($urandom_range(2, 5)) @(negedge clk);
        btn_submit = 1'b1;
      end
      2: begin
        push_exp(1'b0);
        sw      = 8'($urandom);
        prev_sw = sw;
        @(negedge clk);
        n = 0;
        while (phase == 2'd2 && n < 40) begin
          check("input_echo", {24'd0, number}, {24'd0, prev_sw});
          sw      = 8'($urandom);
          prev_sw = sw;
          @(negedge clk);
          n++;
        end
      end
      default: begin
        sw = m_target;
        push_exp(1'b1);
        repeat (13) @(negedge clk);
        btn_submit = 1'b1;
      end
    endcase
    wait_phase(2'd3, 40, "enter_result");
    btn_submit = 1'b0;
    n = 0;
    while (phase == 2'd3 && n < 20) begin
      check("result_number", {24'd0, number}, {24'd0, 8'(model_score)});
      n++;
      @(negedge clk);
    end
    check("result_len", n, 6);
    check("after_result_phase", {30'd0, phase}, 32'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m_lfsr_prev = m_lfsr_cur;
      m_lfsr_cur  = !rst_n ? 8'hA5 : lfsr_ref(m_lfsr_cur);
    end
  end

  // Target tracker: on every SHOW entry the shown value must be the model LFSR of the pulse cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && phase == 2'd1 && prev_phase != 2'd1) begin
        m_target = m_lfsr_prev;
        show_entries++;
        check("show_target", {24'd0, number}, {24'd0, m_target});
      end
      prev_phase = rst_n ? phase : 2'd0;
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && round_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_round_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("last_correct", {31'd0, last_correct}, {31'd0, e.correct});
          check("score_on_done", {24'd0, number}, {24'd0, e.score});
          check("phase_on_done", {30'd0, phase}, 32'd3);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_number", {24'd0, number}, 32'd0);
    check("rst_last_correct", {31'd0, last_correct}, 32'd0);
    check("rst_round_done", {31'd0, round_done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_phase", {30'd0, phase}, 32'd0);
      check("idle_number", {24'd0, number}, 32'd0);
    end

    // Bouncy press then a steady hold: exactly one round start
    btn_submit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_submit = ~btn_submit;
    end
    repeat (10) @(negedge clk);
    check("held_phase", {30'd0, phase}, 32'd1);
    btn_submit = 1'b0;
    check("single_pulse", show_entries, 1);

    do_round(0);
    do_round(2);
    do_round(3);
    for (int i = 0; i < 126; i++) do_round(0);
    check("score_at_max", model_score, 127);
    do_round(0);
    do_round(0);
    for (int i = 0; i < 30; i++) do_round(int'($urandom_range(0, 2)));
    while (model_score > -128) do_round(2);
    do_round(2);
    do_round(2);
    check("sb_empty", sb_q.size(), 0);

    wait_phase(2'd1, 20, "pre_reset_show");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midshow_rst_phase", {30'd0, phase}, 32'd0);
    check("midshow_rst_number", {24'd0, number}, 32'd0);
    rst_n = 1'b1;
    model_score = 0;
    sb_q.delete();
    @(negedge clk);
    check("post_rst_number", {24'd0, number}, 32'd0);
    repeat (2) @(negedge clk);
    btn_submit = 1'b1;
    wait_phase(2'd1, 20, "post_rst_show");
    btn_submit = 1'b0;
    do_round(0);
    check("post_rst_score", model_score, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
